// File: rtl/stack_bus_pkg.sv
// Shared types and default sizes for the stack bus initiator.
package stack_bus_pkg;

    localparam int DATA_W = 4;
    localparam int IDX_W  = 3;
    localparam int DEPTH  = 5;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_GET  = 2'd3
    } stack_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/stack_bus_phy.sv
// IO_DATA tri-state driver and falling-edge read capture for the stack bus.
module stack_bus_phy
    import stack_bus_pkg::*;
#(
    parameter int WIDTH = stack_bus_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drive_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sample,
    output logic [WIDTH-1:0] cap,
    inout  wire  [WIDTH-1:0] io_data
);

    assign io_data = drive_en ? wdata : {WIDTH{1'bz}};

    // The stack drives its reply while CLK is high; sample it mid-cycle.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= '0;
        end else if (sample) begin
            cap <= io_data;
        end
    end

endmodule

// File: rtl/stack_initiator.sv
// Bus master sequencing push/pop/get requests onto the stack bus.
// Optional occupancy checking: define STACK_INIT_DEPTH_CHECK_EN.
module stack_initiator
    import stack_bus_pkg::*;
#(
    parameter int DATA_W = stack_bus_pkg::DATA_W,
    parameter int IDX_W  = stack_bus_pkg::IDX_W,
    parameter int DEPTH  = stack_bus_pkg::DEPTH
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [DATA_W-1:0] REQ_DATA,
    input  logic [IDX_W-1:0]  REQ_INDEX,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic [1:0]        COMMAND,
    output logic [IDX_W-1:0]  INDEX,
    inout  wire  [DATA_W-1:0] IO_DATA
);

    state_e            state;
    stack_cmd_e        op_q;
    stack_cmd_e        req_op;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] cap;
    logic              drive_en;
    logic              sample;
    logic              accept;
    logic              reject;

    assign req_op = stack_cmd_e'(REQ_OP);
    assign accept = REQ_VALID && REQ_READY;
    assign sample = (state == ST_HOLD);

`ifdef STACK_INIT_DEPTH_CHECK_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ;

    always_comb begin
        reject = 1'b0;
        unique case (req_op)
            CMD_PUSH: reject = (int'(occ) >= DEPTH);
            CMD_POP:  reject = (occ == '0);
            CMD_GET:  reject = (int'(REQ_INDEX) >= int'(occ));
            default:  reject = 1'b0;
        endcase
    end

    // Counts entries as commands are issued, so it tracks the stack itself.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            occ <= '0;
        end else if (state == ST_IDLE && accept && !reject) begin
            if (req_op == CMD_PUSH) begin
                occ <= occ + OCC_W'(1);
            end else if (req_op == CMD_POP) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            op_q      <= CMD_NOP;
            data_q    <= '0;
            drive_en  <= 1'b0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            COMMAND   <= CMD_NOP;
            INDEX     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        data_q    <= REQ_DATA;
                        REQ_READY <= 1'b0;
                        if (req_op == CMD_NOP || reject) begin
                            state     <= ST_RESP;
                            RSP_VALID <= 1'b1;
                            RSP_DATA  <= '0;
                            RSP_ERR   <= reject;
                        end else begin
                            state    <= ST_ISSUE;
                            COMMAND  <= req_op;
                            INDEX    <= (req_op == CMD_GET) ? REQ_INDEX : '0;
                            drive_en <= (req_op == CMD_PUSH);
                        end
                    end
                end
                ST_ISSUE: begin
                    drive_en <= 1'b0;
                    if (op_q == CMD_PUSH) begin
                        state     <= ST_RESP;
                        COMMAND   <= CMD_NOP;
                        INDEX     <= '0;
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 1'b0;
                    end else begin
                        // Re-read with GET: no pointer side effect, INDEX kept.
                        state   <= ST_HOLD;
                        COMMAND <= CMD_GET;
                    end
                end
                ST_HOLD: begin
                    state     <= ST_RESP;
                    COMMAND   <= CMD_NOP;
                    INDEX     <= '0;
                    RSP_VALID <= 1'b1;
                    RSP_DATA  <= cap;
                    RSP_ERR   <= 1'b0;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        state     <= ST_IDLE;
                        RSP_VALID <= 1'b0;
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 1'b0;
                        REQ_READY <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    stack_bus_phy #(
        .WIDTH (DATA_W)
    ) u_phy (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .drive_en (drive_en),
        .wdata    (data_q),
        .sample   (sample),
        .cap      (cap),
        .io_data  (IO_DATA)
    );

endmodule

// File: tb/tb_stack_initiator.sv
// Directed bench for stack_initiator with a behavioural 5-entry stack on the bus.
module tb_stack_initiator;

    logic       CLK;
    logic       RESET_N;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [3:0] REQ_DATA;
    logic [2:0] REQ_INDEX;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [1:0] COMMAND;
    logic [2:0] INDEX;
    wire  [3:0] IO_DATA;

    int tests = 0;
    int fails = 0;

    stack_initiator dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OP    (REQ_OP),
        .REQ_DATA  (REQ_DATA),
        .REQ_INDEX (REQ_INDEX),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .COMMAND   (COMMAND),
        .INDEX     (INDEX),
        .IO_DATA   (IO_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural stack: replies are loaded on the rising edge and driven
    // on the following CLK-high phase while the command is POP or GET.
    logic [3:0] mem [5];
    logic [3:0] stk_q;
    logic       stk_en = 1'b0;
    int         sp;

    assign IO_DATA = stk_en ? stk_q : 4'bz;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp    <= 0;
            stk_q <= 4'h0;
            for (int i = 0; i < 5; i++) mem[i] <= 4'h0;
        end else begin
            case (COMMAND)
                2'd1: begin
                    mem[sp] <= IO_DATA;
                    sp      <= (sp + 1) % 5;
                end
                2'd2: begin
                    stk_q <= mem[(sp + 4) % 5];
                    sp    <= (sp + 4) % 5;
                end
                2'd3: stk_q <= mem[(sp + 9 - int'(INDEX) % 5) % 5];
                default: ;
            endcase
        end
    end

    always begin
        @(posedge CLK);
        #1 stk_en = RESET_N && (COMMAND == 2'd2 || COMMAND == 2'd3);
        @(negedge CLK);
        #1 stk_en = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: the initiator drives only on a PUSH command and the
    // bus never carries X/contention while a command is active.
    always @(posedge CLK) begin
        #2;
        if (RESET_N) begin
            check("mon_drive", {31'd0, dut.drive_en}, {31'd0, COMMAND == 2'd1});
            if (COMMAND != 2'd0) begin
                check("mon_known", {31'd0, $isunknown(IO_DATA)}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic txn(input string tag, input logic [1:0] op,
                       input logic [3:0] d, input logic [2:0] ix,
                       input logic [3:0] exp_d, input logic exp_e,
                       input int hold);
        int n = 0;
        while (REQ_READY !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, {31'd0, REQ_READY}, 32'd1);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_DATA  = d;
        REQ_INDEX = ix;
        RSP_READY = (hold == 0);
        tick();
        REQ_VALID = 1'b0;
        if (op != 2'd0 && !exp_e) begin
            check({tag, "_cmd1"}, {30'd0, COMMAND}, {30'd0, op});
            check({tag, "_idx1"}, {29'd0, INDEX}, (op == 2'd3) ? {29'd0, ix} : 32'd0);
            check({tag, "_vld1"}, {31'd0, RSP_VALID}, 32'd0);
            if (op == 2'd1) begin
                check({tag, "_io"}, {28'd0, IO_DATA}, {28'd0, d});
            end else begin
                tick();
                check({tag, "_cmd2"}, {30'd0, COMMAND}, 32'd3);
                check({tag, "_idx2"}, {29'd0, INDEX}, (op == 2'd3) ? {29'd0, ix} : 32'd0);
            end
            tick();
        end
        check({tag, "_cmd"}, {30'd0, COMMAND}, 32'd0);
        check({tag, "_vld"}, {31'd0, RSP_VALID}, 32'd1);
        check({tag, "_data"}, {28'd0, RSP_DATA}, {28'd0, exp_d});
        check({tag, "_err"}, {31'd0, RSP_ERR}, {31'd0, exp_e});
        check({tag, "_busy"}, {31'd0, REQ_READY}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hvld"}, {31'd0, RSP_VALID}, 32'd1);
            check({tag, "_hdata"}, {28'd0, RSP_DATA}, {28'd0, exp_d});
            check({tag, "_hrdy"}, {31'd0, REQ_READY}, 32'd0);
            check({tag, "_hcmd"}, {30'd0, COMMAND}, 32'd0);
        end
        RSP_READY = 1'b1;
        tick();
        check({tag, "_done"}, {31'd0, RSP_VALID}, 32'd0);
        check({tag, "_next"}, {31'd0, REQ_READY}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N   = 1'b0;
        REQ_VALID = 1'b0;
        REQ_OP    = 2'd0;
        REQ_DATA  = 4'h0;
        REQ_INDEX = 3'd0;
        RSP_READY = 1'b1;
        tick();
        tick();
        check("rst_ready", {31'd0, REQ_READY}, 32'd1);
        check("rst_valid", {31'd0, RSP_VALID}, 32'd0);
        check("rst_data", {28'd0, RSP_DATA}, 32'd0);
        check("rst_err", {31'd0, RSP_ERR}, 32'd0);
        check("rst_cmd", {30'd0, COMMAND}, 32'd0);
        check("rst_idx", {29'd0, INDEX}, 32'd0);
        check("rst_drive", {31'd0, dut.drive_en}, 32'd0);
        RESET_N = 1'b1;
        tick();

        txn("pushA", 2'd1, 4'hA, 3'd0, 4'h0, 1'b0, 0);
        txn("popA", 2'd2, 4'h0, 3'd0, 4'hA, 1'b0, 0);

        txn("pushA2", 2'd1, 4'hA, 3'd0, 4'h0, 1'b0, 0);
        txn("pushB", 2'd1, 4'hB, 3'd0, 4'h0, 1'b0, 0);
        txn("pushC", 2'd1, 4'hC, 3'd0, 4'h0, 1'b0, 0);
        txn("get1", 2'd3, 4'h0, 3'd1, 4'hB, 1'b0, 0);
        txn("nop", 2'd0, 4'h5, 3'd0, 4'h0, 1'b0, 0);
        txn("popC_hold", 2'd2, 4'h0, 3'd0, 4'hC, 1'b0, 3);
        txn("get0", 2'd3, 4'h0, 3'd0, 4'hB, 1'b0, 0);

        // Reset in the HOLD cycle of a POP aborts it.
        txn("push7", 2'd1, 4'h7, 3'd0, 4'h0, 1'b0, 0);
        REQ_VALID = 1'b1;
        REQ_OP    = 2'd2;
        tick();
        REQ_VALID = 1'b0;
        tick();
        check("abort_hold", {30'd0, COMMAND}, 32'd3);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("abort_cmd", {30'd0, COMMAND}, 32'd0);
        check("abort_idx", {29'd0, INDEX}, 32'd0);
        check("abort_vld", {31'd0, RSP_VALID}, 32'd0);
        check("abort_drv", {31'd0, dut.drive_en}, 32'd0);
        check("abort_rdy", {31'd0, REQ_READY}, 32'd1);
        RESET_N = 1'b1;
        tick();
        txn("push9", 2'd1, 4'h9, 3'd0, 4'h0, 1'b0, 0);
        txn("pop9", 2'd2, 4'h0, 3'd0, 4'h9, 1'b0, 0);

`ifdef STACK_INIT_DEPTH_CHECK_EN
        txn("pop_empty", 2'd2, 4'h0, 3'd0, 4'h0, 1'b1, 0);
        txn("get_empty", 2'd3, 4'h0, 3'd0, 4'h0, 1'b1, 0);
        txn("fill1", 2'd1, 4'h1, 3'd0, 4'h0, 1'b0, 0);
        txn("fill2", 2'd1, 4'h2, 3'd0, 4'h0, 1'b0, 0);
        txn("fill3", 2'd1, 4'h3, 3'd0, 4'h0, 1'b0, 0);
        txn("fill4", 2'd1, 4'h4, 3'd0, 4'h0, 1'b0, 0);
        txn("fill5", 2'd1, 4'h5, 3'd0, 4'h0, 1'b0, 0);
        txn("push_full", 2'd1, 4'h6, 3'd0, 4'h0, 1'b1, 0);
        txn("get4", 2'd3, 4'h0, 3'd4, 4'h1, 1'b0, 0);
        txn("get5", 2'd3, 4'h0, 3'd5, 4'h0, 1'b1, 0);
        txn("pop5", 2'd2, 4'h0, 3'd0, 4'h5, 1'b0, 0);
`else
        txn("push3", 2'd1, 4'h3, 3'd0, 4'h0, 1'b0, 0);
        txn("get5_wrap", 2'd3, 4'h0, 3'd5, 4'h3, 1'b0, 0);
        txn("pop3", 2'd2, 4'h0, 3'd0, 4'h3, 1'b0, 0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_initiator.md
# stack_initiator

Bus master for the synchronous 5-entry stack. It accepts push/pop/get requests from upstream logic over a valid/ready handshake and sequences them onto the stack's shared COMMAND/INDEX/IO_DATA bus. For reads it captures the stack's tri-stated reply and returns it on a buffered response channel. It is the initiating end of the stack bus protocol and sits between the control datapath and the stack instance.

## Interface
- DATA_W, 4, stack word width
- IDX_W, 3, INDEX width
- DEPTH, 5, stack entries
- CLK  input  1  single clock; rising edge for all state, falling edge for read capture only
- RESET_N  input  1  asynchronous, active-low reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  request accepted on rising CLK when both high
- REQ_OP  input  2  0 NOP, 1 PUSH, 2 POP, 3 GET
- REQ_DATA  input  DATA_W  push data
- REQ_INDEX  input  IDX_W  get offset from top (0 = top)
- RSP_VALID  output  1  response present, held until RSP_READY
- RSP_READY  input  1  response consumed on rising CLK when both high
- RSP_DATA  output  DATA_W  read data (0 for PUSH/NOP/error)
- RSP_ERR  output  1  request rejected (see Configuration)
- COMMAND  output  2  stack bus command, same encoding as REQ_OP
- INDEX  output  IDX_W  stack bus index
- IO_DATA  inout  DATA_W  shared data bus

## Operation
- FSM states: IDLE, ISSUE, HOLD, RESP.
- IDLE: COMMAND=0, INDEX=0, IO_DATA=z, REQ_READY=1. On accept, latch op/data/index.
  - PUSH/POP/GET legal: go to ISSUE.
  - NOP or rejected: go to RESP directly, with no bus activity.
- ISSUE (one cycle): COMMAND=op, INDEX=latched index (POP/PUSH: 0). For PUSH, drive IO_DATA=latched data for this cycle only.
  - PUSH: go to RESP.
  - POP/GET: go to HOLD.
- HOLD (one cycle): COMMAND=3 (GET, no pointer side effect).
  - INDEX = 0 after POP; INDEX = latched index after GET.
  - IO_DATA stays z. The stack drives the reply during the CLK-high phase.
  - The falling-edge capture register samples IO_DATA mid-cycle. Go to RESP.
- RESP: COMMAND=0, RSP_VALID=1 with RSP_DATA/RSP_ERR stable. Return to IDLE on RSP_READY.
- REQ_READY is asserted only in IDLE; one request is outstanding at a time.
- The initiator never drives IO_DATA while COMMAND∈{2,3}.
- INDEX is passed unmodified; the stack applies mod-DEPTH.
- Reset values: state IDLE, COMMAND=0, INDEX=0, IO_DATA=z, REQ_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, occupancy=0.
- Reset asserted mid-operation aborts immediately: the bus releases asynchronously and any pending response is dropped. The system must reset the stack together with this block.

## Timing
- Accept at rising edge a.
- PUSH: COMMAND=1 during cycle a→a+1; RSP_VALID from a+1.
- POP/GET: command during a→a+1, HOLD during a+1→a+2, capture at falling edge inside a+1→a+2; RSP_VALID from a+2.
- NOP/rejected: RSP_VALID from a+1.
- Earliest next accept: the rising edge after the RSP handshake. With RSP_READY tied high, throughput is one PUSH per 3 cycles and one read per 4 cycles.
- RSP_READY low holds RESP indefinitely, and the bus stays at NOP throughout.

## Configuration
- STACK_INIT_DEPTH_CHECK_EN defined: the block keeps an occupancy counter (0..DEPTH) updated when a command is issued.
  - Rejected with RSP_ERR=1 and no bus cycle: POP at 0, PUSH at DEPTH, GET with REQ_INDEX ≥ occupancy.
- Undefined: no counter, RSP_ERR tied 0, and every request is issued. Stack wrap-around is visible to software.

## Structure
- Package stack_bus_pkg holds:
  - enum stack_cmd_e (NOP/PUSH/POP/GET)
  - DATA_W, IDX_W, DEPTH defaults
  - FSM state enum
- Sub-module stack_bus_phy contains:
  - the IO_DATA tri-state driver, with enable = PUSH issue cycle
  - the falling-edge capture register
- The FSM, request/response registers and optional counter stay in stack_initiator.

## Test plan
- PUSH 4'hA, then POP → COMMAND sequence 1,0,…,2,3,0; RSP_DATA=4'hA, RSP_ERR=0 at a+2 of the POP.
- PUSH A, B, C, then GET INDEX=1 → COMMAND 3 for two cycles with INDEX=1; RSP_DATA=4'hB.
- With the macro: POP after reset → RSP_ERR=1, RSP_DATA=0, COMMAND stays 0; a sixth PUSH → RSP_ERR=1.
- RSP_READY held low for 3 cycles after a POP → RSP_VALID/RSP_DATA stable, REQ_READY=0, COMMAND=0 throughout.
- RESET_N low during HOLD → COMMAND=0 and IO_DATA=z immediately, RSP_VALID=0; next PUSH/POP round-trip is correct.
- Bus monitor on every cycle → no X/contention on IO_DATA; the initiator drives only while COMMAND=1.
